// File: rtl/fir_out_reader.sv
// fir_out_reader
// Output-side consumer for the 9-tap low-pass FIR. Drops the samples produced
// while the filter pipeline fills after reset, rounds and saturates each
// 17-bit result to 8 bits, buffers it in a first-word-fall-through FIFO and
// hands it downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst    : system clock (rising edge), synchronous active-high reset
//   fir_out     : 17-bit unsigned filter result
//   fir_valid   : one-cycle strobe, fir_out holds a new sample
//   dout        : scaled sample at the FIFO head (forced to 0 while empty)
//   dout_valid  : FIFO non-empty
//   dout_ready  : downstream accepts dout this cycle
//   level       : FIFO occupancy, 0..DEPTH
//   overflow    : sticky, a qualified sample was refused by a full FIFO
//   drop_cnt    : refused-sample count, saturating at 255
//   warm        : WARMUP samples have been discarded since reset
module fir_out_reader #(
    parameter int unsigned WARMUP = 11,
    parameter int unsigned SHIFT  = 9,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [16:0]   fir_out,
    input  logic          fir_valid,
    output logic [7:0]    dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [7:0]    drop_cnt,
    output logic          warm
);

    // Elaboration-time parameter legality.
    if (SHIFT < 1 || SHIFT > 16) begin : g_bad_shift
        $error("fir_out_reader: SHIFT must be in 1..16");
    end
    if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_bad_depth
        $error("fir_out_reader: DEPTH must be a power of two >= 2 equal to 2**AW");
    end

    localparam int unsigned CW       = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
    localparam logic [CW-1:0] LAST   = (WARMUP == 0) ? '0 : CW'(WARMUP - 1);
    localparam logic [17:0] ROUND    = 18'(1) << (SHIFT - 1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Warm-up control
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_WARMUP,
        ST_RUN
    } state_e;

    state_e        state_q;
    logic [CW-1:0] wcnt_q;
    logic          warm_q;

    // The strobe that brings the count to WARMUP is still discarded because
    // the scaling stage qualifies with warm_q, which only rises afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WARMUP;
            wcnt_q  <= '0;
            warm_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (WARMUP == 0) begin
                        state_q <= ST_RUN;
                        warm_q  <= 1'b1;
                    end else if (fir_valid) begin
                        wcnt_q <= wcnt_q + CW'(1);
                        if (wcnt_q == LAST) begin
                            state_q <= ST_RUN;
                            warm_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    warm_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_WARMUP;
                    warm_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round / shift / saturate stage
    // ------------------------------------------------------------------
    logic [17:0] sum;
    logic [17:0] quo;
    logic [7:0]  sat;
    logic        s_valid_d, s_valid_q;
    logic [7:0]  s_data_d,  s_data_q;

    always_comb begin
        sum       = {1'b0, fir_out} + ROUND;
        quo       = sum >> SHIFT;
        sat       = (quo > 18'd255) ? 8'hFF : quo[7:0];
        s_valid_d = fir_valid & warm_q;
        s_data_d  = s_valid_d ? sat : s_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
        end else begin
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_d, wr_ptr_q;
    logic [AW-1:0] rd_ptr_d, rd_ptr_q;
    logic [AW:0]   level_d,  level_q;
    logic          ovf_d,    ovf_q;
    logic [7:0]    drop_d,   drop_q;
    logic          push, pop, full, accept, refuse;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_comb begin
        push     = s_valid_q;
        pop      = (level_q != '0) & dout_ready;
        full     = (level_q == FULL_LVL);
        accept   = push & (~full | pop);
        refuse   = push & ~accept;

        wr_ptr_d = wr_ptr_q + AW'(accept);
        rd_ptr_d = rd_ptr_q + AW'(pop);

        level_d  = level_q;
        case ({accept, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase

        ovf_d  = ovf_q | refuse;
        drop_d = (refuse && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: entries are only observable behind level_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= s_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dout_valid = (level_q != '0);
    assign dout       = dout_valid ? mem_q[rd_ptr_q] : '0;
    assign level      = level_q;
    assign overflow   = ovf_q;
    assign drop_cnt   = drop_q;
    assign warm       = warm_q;

endmodule

// File: tb/tb_fir_out_reader.sv
module tb_fir_out_reader;

    localparam int WARMUP = 11;
    localparam int SHIFT  = 9;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [16:0]   fir_out;
    logic          fir_valid;
    logic [7:0]    dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [AW:0]   level;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          warm;

    always #5 clk = ~clk;

    fir_out_reader #(
        .WARMUP (WARMUP),
        .SHIFT  (SHIFT),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fir_out    (fir_out),
        .fir_valid  (fir_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .warm       (warm)
    );

    // ------------------------------------------------------------------
    // Behavioural model: a queue of scaled samples plus a one-deep
    // holding slot for the sample currently being scaled.
    // ------------------------------------------------------------------
    int  m_q[$];
    int  m_cnt;
    bit  m_warm;
    bit  m_pend;
    int  m_pendv;
    bit  m_ovf;
    int  m_drop;
    bit  m_pop;
    bit  m_acc;

    function automatic int scale(input int x);
        int r;
        r = (x + (1 << (SHIFT - 1))) / (1 << SHIFT);
        return (r > 255) ? 255 : r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_cnt  = 0;
            m_warm = 1'b0;
            m_pend = 1'b0;
            m_pendv = 0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            m_pop = (m_q.size() != 0) && dout_ready;
            m_acc = m_pend && ((m_q.size() < DEPTH) || m_pop);
            if (m_pop) void'(m_q.pop_front());
            if (m_acc) begin
                m_q.push_back(m_pendv);
            end else if (m_pend) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop = m_drop + 1;
            end
            m_pend  = fir_valid && m_warm;
            m_pendv = scale(int'(fir_out));
            if (!m_warm) begin
                if (fir_valid) m_cnt = m_cnt + 1;
                if (m_cnt >= WARMUP) m_warm = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process (sole owner of the counters)
    // ------------------------------------------------------------------
    int    nchecks = 0;
    int    nerr    = 0;
    bit    chk_en;
    bit    hold_prev = 1'b0;
    int    prev_dout = 0;

    bit    lit_en;
    string lit_name;
    int    lit_valid, lit_dout, lit_level, lit_ovf, lit_drop, lit_warm;

    task automatic chk(input string name, input int act, input int exp);
        nchecks = nchecks + 1;
        if (act != exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("level", int'(level), m_q.size());
            chk("dout_valid", int'(dout_valid), int'(m_q.size() != 0));
            if (m_q.size() != 0) chk("dout", int'(dout), m_q[0]);
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("drop_cnt", int'(drop_cnt), m_drop);
            chk("warm", int'(warm), int'(m_warm));
            if (hold_prev && dout_valid) chk("dout_stable", int'(dout), prev_dout);
            hold_prev = dout_valid && !dout_ready;
            prev_dout = int'(dout);

            if (lit_en) begin
                if (lit_valid >= 0) chk({lit_name, ".valid"}, int'(dout_valid), lit_valid);
                if (lit_dout  >= 0) chk({lit_name, ".dout"},  int'(dout),       lit_dout);
                if (lit_level >= 0) chk({lit_name, ".level"}, int'(level),      lit_level);
                if (lit_ovf   >= 0) chk({lit_name, ".ovf"},   int'(overflow),   lit_ovf);
                if (lit_drop  >= 0) chk({lit_name, ".drop"},  int'(drop_cnt),   lit_drop);
                if (lit_warm  >= 0) chk({lit_name, ".warm"},  int'(warm),       lit_warm);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    // Hand-computed expectation for the current cycle; -1 skips a field.
    task automatic set_lit(input string n, input int v, input int d, input int l,
                           input int o, input int dr, input int w);
        lit_name  = n;
        lit_valid = v;
        lit_dout  = d;
        lit_level = l;
        lit_ovf   = o;
        lit_drop  = dr;
        lit_warm  = w;
        lit_en    = 1'b1;
    endtask

    task automatic pulse(input int v);
        fir_out   = 17'(v);
        fir_valid = 1'b1;
        cyc();
        fir_valid = 1'b0;
    endtask

    int rin[6]  = '{255, 256, 767, 768, 130560, 131071};
    int rexp[6] = '{0, 1, 1, 2, 255, 255};

    initial begin
        rst        = 1'b1;
        fir_valid  = 1'b0;
        fir_out    = '0;
        dout_ready = 1'b0;
        chk_en     = 1'b0;
        lit_en     = 1'b0;

        // Reset state
        cyc();
        chk_en = 1'b1;
        set_lit("reset", 0, 0, 0, 0, 0, 0);
        cyc();
        rst = 1'b0;

        // 1. Warm-up: 11 consecutive strobes are discarded
        for (int i = 0; i < WARMUP; i++) begin
            fir_out   = 17'd1000;
            fir_valid = 1'b1;
            cyc();
        end
        fir_valid = 1'b0;
        set_lit("warmup_done", 0, -1, 0, 0, 0, 1);
        pulse(1000);
        set_lit("latency_1", 0, -1, 0, 0, 0, 1);
        cyc();
        set_lit("first_out", 1, 2, 1, 0, 0, 1);
        dout_ready = 1'b1;
        cyc();
        dout_ready = 1'b0;

        // 2. Rounding and saturation
        dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pulse(rin[i]);
            cyc();
            set_lit("round", 1, rexp[i], 1, 0, 0, 1);
            cyc();
            cyc();
        end

        // 3. Fill past full, then drain in order
        dout_ready = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            fir_out   = 17'(k * 512);
            fir_valid = 1'b1;
            cyc();
        end
        fir_valid = 1'b0;
        cyc();
        dout_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            set_lit("drain", 1, k, 17 - k, 1, 2, 1);
            cyc();
        end
        set_lit("drained", 0, -1, 0, 1, 2, 1);
        dout_ready = 1'b0;

        // 4. Push and pop together while full
        for (int k = 21; k <= 36; k++) begin
            fir_out   = 17'(k * 512);
            fir_valid = 1'b1;
            cyc();
        end
        fir_valid = 1'b0;
        cyc();
        set_lit("refill", 1, 21, 16, 1, 2, 1);
        pulse(40 * 512);
        dout_ready = 1'b1;
        cyc();
        for (int j = 0; j < 16; j++) begin
            set_lit("simul", 1, (j < 15) ? 22 + j : 40, 16 - j, 1, 2, 1);
            cyc();
        end
        set_lit("simul_empty", 0, -1, 0, 1, 2, 1);
        dout_ready = 1'b0;

        // 5. Random backpressure with continuous input
        for (int i = 0; i < 200; i++) begin
            fir_out    = 17'($urandom_range(0, 131071));
            fir_valid  = 1'b1;
            dout_ready = 1'($urandom_range(0, 1));
            cyc();
        end

        // drop_cnt saturation
        dout_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            fir_out   = 17'(i * 300);
            fir_valid = 1'b1;
            cyc();
        end
        fir_valid = 1'b0;
        cyc();
        set_lit("drop_sat", 1, -1, 16, 1, 255, 1);

        // 6. Reset mid-stream at level 7
        dout_ready = 1'b1;
        repeat (9) cyc();
        dout_ready = 1'b0;
        set_lit("level7", 1, -1, 7, 1, 255, 1);
        rst       = 1'b1;
        fir_out   = 17'd131071;
        fir_valid = 1'b1;
        cyc();
        rst       = 1'b0;
        fir_valid = 1'b0;
        set_lit("mid_reset", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < WARMUP; i++) begin
            fir_out   = 17'(5 * 512);
            fir_valid = 1'b1;
            cyc();
        end
        fir_valid = 1'b0;
        set_lit("rewarm", 0, -1, 0, 0, 0, 1);
        pulse(5 * 512);
        cyc();
        set_lit("rewarm_out", 1, 5, 1, 0, 0, 1);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
